// File: rtl/osc_bank_pkg.sv
// Shared types and default sizes for the multi-voice oscillator bank.
package osc_pkg;
  localparam int VOICES_DEF  = 8;
  localparam int PHASE_W_DEF = 24;
  localparam int OUT_W_DEF   = 12;

  typedef enum logic [1:0] {SAW = 2'd0, SQUARE = 2'd1, TRI = 2'd2, PULSE25 = 2'd3} wave_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/osc_bank_if.sv
// Config write bus + sample stream of osc_bank; mix outputs exist only with OSC_BANK_MIX_EN.
interface osc_bank_if import osc_pkg::*; #(
  parameter int VOICES  = VOICES_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
);
  localparam int VI_W = $clog2(VOICES);

  logic                     sample_tick;
  logic                     cfg_we;
  logic [VI_W-1:0]          cfg_voice;
  logic [PHASE_W-1:0]       cfg_inc;
  logic [1:0]               cfg_wave;
  logic                     cfg_enable;
  logic                     busy;
  logic                     out_valid;
  logic [VI_W-1:0]          out_voice;
  logic signed [OUT_W-1:0]  out_sample;
  logic                     overrun;
`ifdef OSC_BANK_MIX_EN
  logic                          mix_valid;
  logic signed [OUT_W+VI_W-1:0]  mix_sample;

  modport master (output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_enable,
                  input  busy, out_valid, out_voice, out_sample, overrun, mix_valid, mix_sample);
  modport slave  (input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_enable,
                  output busy, out_valid, out_voice, out_sample, overrun, mix_valid, mix_sample);
`else
  modport master (output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_enable,
                  input  busy, out_valid, out_voice, out_sample, overrun);
  modport slave  (input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_wave, cfg_enable,
                  output busy, out_valid, out_voice, out_sample, overrun);
`endif
endinterface

// File: rtl/osc_wave_shaper.sv
// Combinational phase -> signed sample for the four waveform modes.
module osc_wave_shaper import osc_pkg::*; #(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic [PHASE_W-1:0]      phase,
  input  wave_t                   wave,
  output logic signed [OUT_W-1:0] sample
);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

  logic             msb;
  logic [OUT_W-1:0] q, top, t;

  always_comb begin
    sample = '0;
    msb    = phase[PHASE_W-1];
    q      = phase[PHASE_W-2 -: OUT_W];
    top    = phase[PHASE_W-1 -: OUT_W];
    t      = msb ? ~q : q;
    // Inverting the MSB maps offset-binary onto two's complement.
    case (wave)
      SAW:     sample = {~top[OUT_W-1], top[OUT_W-2:0]};
      SQUARE:  sample = msb ? NEG_MAX : POS_MAX;
      TRI:     sample = {~t[OUT_W-1], t[OUT_W-2:0]};
      PULSE25: sample = (phase[PHASE_W-1 -: 2] == 2'b00) ? POS_MAX : NEG_MAX;
    endcase
  end

  generate
    if (PHASE_W - OUT_W >= 2) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^phase[PHASE_W-OUT_W-2:0];
    end
  endgenerate
endmodule

// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one voice per clock per sample tick through a shared shaper.
// Optional summed output per walk when OSC_BANK_MIX_EN is defined.
module osc_bank import osc_pkg::*; #(
  parameter int VOICES  = VOICES_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic     CLK100MHZ,
  input  logic     reset,
  osc_bank_if.slave bus
);
  localparam int VI_W = $clog2(VOICES);

  state_t                  st, st_nx;
  logic [VI_W-1:0]         k, k_nx;
  logic                    proc;
  logic [PHASE_W-1:0]      phase [VOICES];
  logic [PHASE_W-1:0]      inc_r [VOICES];
  wave_t                   wave_r [VOICES];
  logic [VOICES-1:0]       en_r;
  logic signed [OUT_W-1:0] shp;
  logic                    ov_r, oflow_r;
  logic [VI_W-1:0]         ovoice_r;
  logic signed [OUT_W-1:0] osamp_r;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      st <= IDLE;
      k  <= '0;
    end else begin
      st <= st_nx;
      k  <= k_nx;
    end
  end

  always_comb begin
    st_nx = st;
    k_nx  = k;
    proc  = 1'b0;
    case (st)
      IDLE: if (bus.sample_tick) begin
        st_nx = RUN;
        k_nx  = '0;
      end
      RUN: begin
        proc = 1'b1;
        k_nx = k + 1'b1;
        if (k == VI_W'(VOICES-1)) st_nx = IDLE;
      end
    endcase
  end

  osc_wave_shaper #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_shp (
    .phase (phase[k]),
    .wave  (wave_r[k]),
    .sample(shp)
  );

  // Processing reads pre-edge values, so a same-cycle config write lands after this walk uses the old ones.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i]  <= '0;
        inc_r[i]  <= '0;
        wave_r[i] <= SAW;
      end
      en_r     <= '0;
      ov_r     <= 1'b0;
      ovoice_r <= '0;
      osamp_r  <= '0;
      oflow_r  <= 1'b0;
    end else begin
      ov_r <= proc;
      if (proc) begin
        ovoice_r <= k;
        osamp_r  <= en_r[k] ? shp : '0;
        phase[k] <= en_r[k] ? phase[k] + inc_r[k] : '0;
      end
      if (st == RUN && bus.sample_tick) oflow_r <= 1'b1;
      if (bus.cfg_we) begin
        inc_r[bus.cfg_voice]  <= bus.cfg_inc;
        wave_r[bus.cfg_voice] <= wave_t'(bus.cfg_wave);
        en_r[bus.cfg_voice]   <= bus.cfg_enable;
      end
    end
  end

  assign bus.busy       = (st == RUN);
  assign bus.out_valid  = ov_r;
  assign bus.out_voice  = ovoice_r;
  assign bus.out_sample = osamp_r;
  assign bus.overrun    = oflow_r;

`ifdef OSC_BANK_MIX_EN
  localparam int MIX_W = OUT_W + VI_W;
  logic signed [MIX_W-1:0] acc, mix_r, sx;
  logic                    mix_v;

  assign sx = {{VI_W{osamp_r[OUT_W-1]}}, osamp_r};

  // Total is taken from acc + last sample directly, so a tick landing on the last output may clear acc safely.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      acc   <= '0;
      mix_r <= '0;
      mix_v <= 1'b0;
    end else begin
      mix_v <= 1'b0;
      if (ov_r && ovoice_r == VI_W'(VOICES-1)) begin
        mix_r <= acc + sx;
        mix_v <= 1'b1;
      end
      if (st == IDLE && bus.sample_tick) acc <= '0;
      else if (ov_r)                     acc <= acc + sx;
    end
  end

  assign bus.mix_valid  = mix_v;
  assign bus.mix_sample = mix_r;
`endif
endmodule

// File: tb/tb_osc_bank.sv
// Self-checking bench for osc_bank: scoreboard model per walk plus constant waveform tables.
module tb_osc_bank;
  import osc_pkg::*;
  localparam int V = 8, PW = 24, OW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osc_bank_if #(.VOICES(V), .PHASE_W(PW), .OUT_W(OW)) bus();
  osc_bank #(.VOICES(V), .PHASE_W(PW), .OUT_W(OW)) dut (.CLK100MHZ(clk), .reset(rst), .bus(bus));

  typedef struct {int voice; int sample; int cyc;} exp_t;
  typedef struct {logic [1:0] wave; logic [PW-1:0] inc; int e0; int e1; int e2; int e3;} vec_t;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor records everything the DUT emits; the main process compares
  int g_voice[4096], g_sample[4096], g_cyc[4096];
  int gwr = 0, grd = 0;
  always @(negedge clk) if (bus.out_valid) begin
    g_voice[gwr % 4096]  = int'(bus.out_voice);
    g_sample[gwr % 4096] = int'(bus.out_sample);
    g_cyc[gwr % 4096]    = cyc;
    gwr = gwr + 1;
  end
`ifdef OSC_BANK_MIX_EN
  int m_val[256], m_cyc[256];
  int mwr = 0, mrd = 0;
  always @(negedge clk) if (bus.mix_valid) begin
    m_val[mwr % 256] = int'(bus.mix_sample);
    m_cyc[mwr % 256] = cyc;
    mwr = mwr + 1;
  end
`endif

  logic [PW-1:0] m_phase[V], m_inc[V];
  logic [1:0]    m_wave[V];
  bit            m_en[V];
  exp_t exp_q[$], mix_q[$];
  int   last_s[V];
  int   last_mix;

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int ref_sample(input logic [PW-1:0] p, input logic [1:0] w);
    int u;
    case (w)
      2'd0: return int'(p >> 12) - 2048;
      2'd1: return (p < 24'h800000) ? 2047 : -2048;
      2'd2: begin
        u = int'(p >> 11);
        return ((u < 4096) ? u : 8191 - u) - 2048;
      end
      default: return (p < 24'h400000) ? 2047 : -2048;
    endcase
  endfunction

  task automatic clear_model();
    for (int v = 0; v < V; v++) begin
      m_phase[v] = '0; m_inc[v] = '0; m_wave[v] = 2'd0; m_en[v] = 1'b0;
    end
    exp_q.delete();
    mix_q.delete();
  endtask

  task automatic push_walk(input int t0);
    int s, sum;
    exp_t e;
    sum = 0;
    for (int v = 0; v < V; v++) begin
      s = m_en[v] ? ref_sample(m_phase[v], m_wave[v]) : 0;
      m_phase[v] = m_en[v] ? m_phase[v] + m_inc[v] : '0;
      sum += s;
      e.voice = v; e.sample = s; e.cyc = t0 + 2 + v;
      exp_q.push_back(e);
    end
    e.voice = 0; e.sample = sum; e.cyc = t0 + V + 2;
    mix_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (grd < gwr) begin
      if (exp_q.size() == 0) begin
        check("extra_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_voice", g_voice[grd % 4096], e.voice);
        check("out_sample", g_sample[grd % 4096], e.sample);
        check("out_cycle", g_cyc[grd % 4096], e.cyc);
        last_s[e.voice] = g_sample[grd % 4096];
      end
      grd++;
    end
`ifdef OSC_BANK_MIX_EN
    while (mrd < mwr) begin
      if (mix_q.size() == 0) begin
        check("extra_mix_valid", 1, 0);
      end else begin
        e = mix_q.pop_front();
        check("mix_sample", m_val[mrd % 256], e.sample);
        check("mix_cycle", m_cyc[mrd % 256], e.cyc);
        last_mix = m_val[mrd % 256];
      end
      mrd++;
    end
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    drain();
    clear_model();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_voice"}, int'(bus.out_voice), 0);
    check({tag, "_out_sample"}, int'(bus.out_sample), 0);
`ifdef OSC_BANK_MIX_EN
    check({tag, "_mix_valid"}, int'(bus.mix_valid), 0);
    check({tag, "_mix_sample"}, int'(bus.mix_sample), 0);
`endif
  endtask

  task automatic cfg(input int v, input logic [1:0] w, input logic [PW-1:0] inc, input bit en);
    bus.cfg_we = 1'b1; bus.cfg_voice = 3'(v); bus.cfg_wave = w;
    bus.cfg_inc = inc; bus.cfg_enable = en;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    m_inc[v] = inc; m_wave[v] = w; m_en[v] = en;
  endtask

  task automatic walk(input bit chk_busy);
    push_walk(cyc);
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    for (int i = 1; i <= V + 1; i++) begin
      @(negedge clk);
      if (chk_busy) check("busy_window", int'(bus.busy), (i <= V) ? 1 : 0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    drain();
    check("walk_drained", exp_q.size(), 0);
  endtask

  vec_t tbl[4];
  int   ex[4];
  int   g0;

  initial begin
    bus.sample_tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_voice = '0;
    bus.cfg_inc = '0; bus.cfg_wave = '0; bus.cfg_enable = 1'b0;
    tbl[0] = '{wave: 2'd1, inc: 24'h400000, e0: 2047,  e1: 2047,  e2: -2048, e3: -2048};
    tbl[1] = '{wave: 2'd2, inc: 24'h400000, e0: -2048, e1: 0,     e2: 2047,  e3: -1};
    tbl[2] = '{wave: 2'd3, inc: 24'h400000, e0: 2047,  e1: -2048, e2: -2048, e3: -2048};
    tbl[3] = '{wave: 2'd0, inc: 24'h400000, e0: -2048, e1: -1024, e2: 0,     e3: 1024};
    last_mix = 0;

    do_reset();
    check_zero_outputs("reset");
    check("reset_overrun", int'(bus.overrun), 0);

    // all voices disabled: eight zero samples, busy window t+1..t+8
    walk(1'b1);
`ifdef OSC_BANK_MIX_EN
    check("mix_all_off", last_mix, 0);
`endif

    // constant waveform tables on voice 1
    for (int n = 0; n < 4; n++) begin
      do_reset();
      cfg(1, tbl[n].wave, tbl[n].inc, 1'b1);
      ex = '{tbl[n].e0, tbl[n].e1, tbl[n].e2, tbl[n].e3};
      for (int j = 0; j < 4; j++) begin
        walk(1'b0);
        check($sformatf("table%0d_tick%0d", n, j), last_s[1], ex[j]);
      end
    end

    // saw on voice 0 wraps after 16 ticks
    do_reset();
    cfg(0, 2'd0, 24'h100000, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      walk(1'b0);
      if (i == 1)  check("saw_tick1", last_s[0], -2048);
      if (i == 2)  check("saw_tick2", last_s[0], -1792);
      if (i == 3)  check("saw_tick3", last_s[0], -1536);
      if (i == 17) check("saw_wrap", last_s[0], -2048);
    end

    // tick re-asserted at t+3: dropped, overrun sticky
    push_walk(cyc);
    g0 = gwr;
    bus.sample_tick = 1'b1; @(posedge clk); #1;
    bus.sample_tick = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1; @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    repeat (V + 4) begin @(posedge clk); #1; end
    drain();
    check("overrun_drained", exp_q.size(), 0);
    check("overrun_count", gwr - g0, V);
    check("overrun_set", int'(bus.overrun), 1);
    walk(1'b0);
    check("overrun_sticky", int'(bus.overrun), 1);

    // config write to voice 2 in the cycle voice 2 is processed
    do_reset();
    push_walk(cyc);
    bus.sample_tick = 1'b1; @(posedge clk); #1;
    bus.sample_tick = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    cfg(2, 2'd0, 24'h100000, 1'b1);
    repeat (V + 1) begin @(posedge clk); #1; end
    drain();
    check("collide_old", last_s[2], 0);
    walk(1'b0);
    check("collide_new1", last_s[2], -2048);
    walk(1'b0);
    check("collide_new2", last_s[2], -1792);

    // all square from phase 0, then reset in the middle of a walk
    do_reset();
    for (int v = 0; v < V; v++) cfg(v, 2'd1, '0, 1'b1);
    walk(1'b0);
    check("square_v7", last_s[7], 2047);
`ifdef OSC_BANK_MIX_EN
    check("mix_all_square", last_mix, 16376);
`endif
    push_walk(cyc);
    g0 = gwr;
    bus.sample_tick = 1'b1; @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    check_zero_outputs("abort");
    check("abort_overrun", int'(bus.overrun), 0);
    drain();
    clear_model();
    repeat (14) begin @(posedge clk); #1; end
    drain();
    check("abort_out_count", gwr - g0, 3);
    check_zero_outputs("abort_idle");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
